// File: rtl/cfg_chain_loader.sv
// Bit-serial loader for the scff configuration chain: streams words into the
// chain head LSB-first and returns the bits falling out of the tail as words.
module cfg_chain_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              chain_d,
  output logic              chain_shift,
  input  logic              chain_q
);

  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NWORDS - 1) * WORD_W;
  localparam int WCW       = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int BCW       = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_EMIT
  } state_t;

  state_t            state, state_next;
  logic [WCW-1:0]    word_cnt, word_cnt_next;
  logic [BCW-1:0]    bit_cnt, bit_cnt_next;
  logic [BCW-1:0]    nbits, nbits_next;
  logic [WORD_W-1:0] shreg, shreg_next;
  logic [WORD_W-1:0] capture, capture_next;
  logic              done_next;
  logic              last_word;

  assign last_word = (word_cnt == WCW'(NWORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      word_cnt <= '0;
      bit_cnt  <= '0;
      nbits    <= '0;
      shreg    <= '0;
      capture  <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      word_cnt <= word_cnt_next;
      bit_cnt  <= bit_cnt_next;
      nbits    <= nbits_next;
      shreg    <= shreg_next;
      capture  <= capture_next;
      done     <= done_next;
    end
  end

  always_comb begin
    state_next    = state;
    word_cnt_next = word_cnt;
    bit_cnt_next  = bit_cnt;
    nbits_next    = nbits;
    shreg_next    = shreg;
    capture_next  = capture;
    done_next     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next    = S_FETCH;
          word_cnt_next = '0;
          bit_cnt_next  = '0;
        end
      end
      S_FETCH: begin
        if (in_valid) begin
          shreg_next   = in_data;
          nbits_next   = last_word ? BCW'(LAST_BITS) : BCW'(WORD_W);
          capture_next = '0;
          bit_cnt_next = '0;
          state_next   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // The tail bit is sampled at the same edge that advances the chain.
        capture_next = capture | ({{(WORD_W-1){1'b0}}, chain_q} << bit_cnt);
        shreg_next   = shreg >> 1;
        bit_cnt_next = bit_cnt + BCW'(1);
        if (bit_cnt == nbits - BCW'(1)) begin
          state_next = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (last_word) begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end else begin
            word_cnt_next = word_cnt + WCW'(1);
            state_next    = S_FETCH;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Every output is a decode of registered state; no input reaches an output.
  assign busy        = (state != S_IDLE);
  assign in_ready    = (state == S_FETCH);
  assign out_valid   = (state == S_EMIT);
  assign chain_shift = (state == S_SHIFT);
  assign chain_d     = chain_shift & shreg[0];
  assign out_data    = capture;

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Scoreboard bench for cfg_chain_loader: a 64-bit/8-bit instance for the main
// scenarios and a 20-bit/8-bit instance for the partial last word.
module tb_cfg_chain_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Instance A: CHAIN_LEN=64
  logic        a_start = 0, a_in_valid = 0, a_out_ready = 1;
  logic [7:0]  a_in_data = 0;
  logic        a_busy, a_done, a_in_ready, a_out_valid, a_chain_d, a_chain_shift, a_chain_q;
  logic [7:0]  a_out_data;
  logic [63:0] a_chain = '0;
  logic [63:0] a_load_val = '0;
  logic        a_load = 0;
  int          a_shifts = 0, a_dones = 0, a_done_cyc = 0;
  logic [7:0]  a_exp[$];

  // Instance B: CHAIN_LEN=20
  logic        b_start = 0, b_in_valid = 0, b_out_ready = 1;
  logic [7:0]  b_in_data = 0;
  logic        b_busy, b_done, b_in_ready, b_out_valid, b_chain_d, b_chain_shift, b_chain_q;
  logic [7:0]  b_out_data;
  logic [19:0] b_chain = '0;
  logic [19:0] b_load_val = '0;
  logic        b_load = 0;
  int          b_shifts = 0, b_dones = 0, b_done_cyc = 0;
  logic [7:0]  b_exp[$];

  assign a_chain_q = a_chain[63];
  assign b_chain_q = b_chain[19];

  cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(64)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .chain_d(a_chain_d), .chain_shift(a_chain_shift), .chain_q(a_chain_q)
  );

  cfg_chain_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .chain_d(b_chain_d), .chain_shift(b_chain_shift), .chain_q(b_chain_q)
  );

  // Behavioural scff chains: bit 0 is the head, the top bit is the tail.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_load) a_chain <= a_load_val;
    else if (a_chain_shift) begin
      a_chain  <= {a_chain[62:0], a_chain_d};
      a_shifts <= a_shifts + 1;
    end
    if (b_load) b_chain <= b_load_val;
    else if (b_chain_shift) begin
      b_chain  <= {b_chain[18:0], b_chain_d};
      b_shifts <= b_shifts + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // Monitors: pop the scoreboard whenever a readback word is handed over.
  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      if (a_exp.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected_word: got %0h expected none", a_out_data);
      end else check("a_readback", a_out_data, a_exp.pop_front());
    end
    if (!rst && b_out_valid && b_out_ready) begin
      if (b_exp.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected_word: got %0h expected none", b_out_data);
      end else check("b_readback", b_out_data, b_exp.pop_front());
    end
    if (a_done) begin a_dones++; a_done_cyc = cyc; end
    if (b_done) begin b_dones++; b_done_cyc = cyc; end
  end

  task automatic feed_a(input logic [7:0] d);
    int t;
    a_in_data = d; a_in_valid = 1;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (a_in_ready) break;
      t++;
      if (t > 300) begin timeout("a_feed"); break; end
    end
    @(posedge clk); #1;
    a_in_valid = 0;
  endtask

  task automatic feed_b(input logic [7:0] d);
    int t;
    b_in_data = d; b_in_valid = 1;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (b_in_ready) break;
      t++;
      if (t > 300) begin timeout("b_feed"); break; end
    end
    @(posedge clk); #1;
    b_in_valid = 0;
  endtask

  task automatic feeder_a(input logic [63:0] words, input int in_stall, input int restart_w);
    int t;
    for (int w = 0; w < 8; w++) begin
      if (w == in_stall) begin
        t = 0;
        while (1) begin
          @(negedge clk);
          if (a_in_ready) break;
          t++;
          if (t > 300) begin timeout("a_stall_fetch"); break; end
        end
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          check("a_fetch_stall_shift", a_chain_shift, 1'b0);
          check("a_fetch_stall_ready", a_in_ready, 1'b1);
        end
        @(posedge clk); #1;
      end
      feed_a(words[8*w +: 8]);
      if (w == restart_w) begin
        a_start = 1; @(posedge clk); #1; a_start = 0;
      end
    end
  endtask

  task automatic drainer_a(input int out_stall);
    int t;
    for (int w = 0; w < 8; w++) begin
      if (w == out_stall) a_out_ready = 0;
      t = 0;
      while (1) begin
        @(negedge clk);
        if (a_out_valid) break;
        t++;
        if (t > 300) begin timeout("a_drain"); break; end
      end
      if (w == out_stall) begin
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          check("a_emit_stall_data", a_out_data, a_exp.size() > 0 ? a_exp[0] : 8'h00);
          check("a_emit_stall_valid", a_out_valid, 1'b1);
          check("a_emit_stall_shift", a_chain_shift, 1'b0);
        end
        @(posedge clk); #1;
        a_out_ready = 1;
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic load_a(input logic [63:0] words, input int in_stall, input int out_stall,
                        input int restart_w, input int exp_lat);
    int s0, d0, t0, t;
    s0 = a_shifts; d0 = a_dones;
    a_start = 1;
    @(posedge clk); #1;
    t0 = cyc;
    a_start = 0;
    check("a_busy_after_start", a_busy, 1'b1);
    fork
      feeder_a(words, in_stall, restart_w);
      drainer_a(out_stall);
    join
    t = 0;
    while (a_dones == d0 && t < 50) begin @(negedge clk); t++; end
    if (a_dones == d0) timeout("a_done");
    repeat (4) @(negedge clk);
    check("a_done_pulses", a_dones - d0, 1);
    check("a_shift_count", a_shifts - s0, 64);
    check("a_busy_idle", a_busy, 1'b0);
    if (exp_lat > 0) check("a_done_latency", a_done_cyc - t0, exp_lat);
    @(posedge clk); #1;
  endtask

  task automatic check_chain_a(input logic [63:0] words);
    logic [7:0] got;
    for (int w = 0; w < 8; w++) begin
      for (int b = 0; b < 8; b++) got[b] = a_chain[63 - (8*w + b)];
      check("a_chain_word", got, words[8*w +: 8]);
    end
  endtask

  task automatic push_a(input logic [63:0] words);
    for (int w = 0; w < 8; w++) a_exp.push_back(words[8*w +: 8]);
  endtask

  task automatic load_b(input logic [23:0] words);
    int s0, d0, t0, t;
    s0 = b_shifts; d0 = b_dones;
    b_start = 1;
    @(posedge clk); #1;
    t0 = cyc;
    b_start = 0;
    for (int w = 0; w < 3; w++) feed_b(words[8*w +: 8]);
    t = 0;
    while (b_dones == d0 && t < 50) begin @(negedge clk); t++; end
    if (b_dones == d0) timeout("b_done");
    repeat (3) @(negedge clk);
    check("b_done_pulses", b_dones - d0, 1);
    check("b_shift_count", b_shifts - s0, 20);
    check("b_done_latency", b_done_cyc - t0, 26);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w18, wa5, w3c;
    logic [7:0]  bw;
    int s0;
    w18 = 64'h0807060504030201;
    wa5 = {8{8'hA5}};
    w3c = {8{8'h3C}};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", a_busy, 1'b0);
    check("rst_done", a_done, 1'b0);
    check("rst_in_ready", a_in_ready, 1'b0);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_chain_shift", a_chain_shift, 1'b0);
    check("rst_chain_d", a_chain_d, 1'b0);
    check("rst_out_data", a_out_data, 8'h00);
    rst = 0;
    @(posedge clk); #1;

    // Basic load over an all-ones chain
    a_load_val = '1; b_load_val = '1; a_load = 1; b_load = 1;
    @(posedge clk); #1;
    a_load = 0; b_load = 0;
    push_a({8{8'hFF}});
    load_a(w18, -1, -1, -1, 80);
    check_chain_a(w18);

    // Round trip
    push_a(w18);
    load_a(wa5, -1, -1, -1, 80);
    push_a(wa5);
    load_a(w3c, -1, -1, -1, 80);
    check_chain_a(w3c);

    // Backpressure on both sides
    push_a(w3c);
    load_a(w18, 1, 3, -1, 0);
    check_chain_a(w18);

    // Extra start while busy is ignored
    push_a(w18);
    load_a(wa5, -1, -1, 2, 80);
    check_chain_a(wa5);

    // Reset on the third shift cycle of word 2
    a_exp.push_back(8'hA5);
    s0 = a_shifts;
    a_start = 1; @(posedge clk); #1; a_start = 0;
    feed_a(8'h11);
    feed_a(8'h22);
    @(posedge clk); @(posedge clk); #2;
    rst = 1;
    #1;
    check("mid_rst_shift", a_chain_shift, 1'b0);
    check("mid_rst_busy", a_busy, 1'b0);
    check("mid_rst_chain_d", a_chain_d, 1'b0);
    check("mid_rst_out_data", a_out_data, 8'h00);
    check("mid_rst_in_ready", a_in_ready, 1'b0);
    @(posedge clk); #1;
    rst = 0;
    check("mid_rst_partial_shifts", a_shifts - s0, 10);
    check("mid_rst_queue_empty", a_exp.size(), 0);
    for (int w = 0; w < 7; w++) a_exp.push_back(8'h69);
    a_exp.push_back(8'h84);
    load_a(w18, -1, -1, -1, 80);
    check_chain_a(w18);

    // Partial last word on the 20-cell chain
    b_exp.push_back(8'hFF); b_exp.push_back(8'hFF); b_exp.push_back(8'h0F);
    load_b(24'hF73412);
    for (int b = 0; b < 8; b++) bw[b] = b_chain[19 - b];
    check("b_chain_w0", bw, 8'h12);
    for (int b = 0; b < 8; b++) bw[b] = b_chain[19 - (8 + b)];
    check("b_chain_w1", bw, 8'h34);
    bw = '0;
    for (int b = 0; b < 4; b++) bw[b] = b_chain[19 - (16 + b)];
    check("b_chain_w2", bw, 8'h07);
    b_exp.push_back(8'h12); b_exp.push_back(8'h34); b_exp.push_back(8'h07);
    load_b(24'h000000);
    check("b_chain_cleared", b_chain, 20'h00000);

    check("a_queue_drained", a_exp.size(), 0);
    check("b_queue_drained", b_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cfg_chain_loader.md
# cfg_chain_loader

Serial configuration-chain driver for the qlf_k4n8 fabric. It accepts configuration words over a valid/ready stream and shifts them bit-serially into the chain of `scff` configuration flops. It also captures the bits that fall out of the chain tail and returns them as readback words. It sits between the configuration port and the head/tail of the `scff` chain.

## Interface

Parameters:
- `WORD_W`, default 8: width of the input and readback words (≥2).
- `CHAIN_LEN`, default 64: number of `scff` cells in the chain (≥1).

Ports:
- `clk`  in  1  clock; the `scff` chain shares this clock.
- `rst`  in  1  reset. Asynchronous, active-high.
- `start`  in  1  single-cycle request to begin a full chain load.
- `busy`  out  1  high from accepted `start` until the cycle `done` pulses.
- `done`  out  1  one-cycle pulse when the final readback word is taken.
- `in_data`  in  WORD_W  configuration word. Bit 0 is shifted first.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts `in_data` this cycle.
- `out_data`  out  WORD_W  readback word. Bit 0 is the first bit captured.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts `out_data`.
- `chain_d`  out  1  serial data to the chain head.
- `chain_shift`  out  1  chain advances one position at this rising edge.
- `chain_q`  in  1  chain tail output, i.e. the bit leaving the chain on a shift.

## Operation

- `NWORDS` = ceil(`CHAIN_LEN` / `WORD_W`).
  - Every word except the last carries `WORD_W` bits.
  - The last word carries `CHAIN_LEN − (NWORDS−1)·WORD_W` bits, taken from its low bits. Its upper bits are ignored.
- State machine:
  - **IDLE**
    - `busy`=0, `in_ready`=0.
    - `start`=1 → FETCH. Clear the word counter and the bit counter. Set `busy`=1 from the next cycle.
  - **FETCH**
    - `in_ready`=1.
    - On `in_valid`&&`in_ready`:
      - latch `in_data` into the shift register;
      - set `nbits` = `WORD_W`, or the residual count for the last word;
      - clear the capture register;
      - go to SHIFT.
  - **SHIFT**
    - `chain_shift`=1 every cycle; `chain_d` = shift register bit 0.
    - Each cycle:
      - sample `chain_q` into capture bit `i` (`i` = bit index within the word);
      - shift the register right.
    - After `nbits` cycles → EMIT.
  - **EMIT**
    - `out_valid`=1; `out_data` = capture register. Unused upper bits are 0.
    - On `out_ready`:
      - if this was the last word: go to IDLE, `done`=1 for one cycle, `busy`=0;
      - otherwise: increment the word counter and go to FETCH.
- `start` is ignored while `busy`=1.
- `chain_d`=0 and `chain_shift`=0 in every state except SHIFT.
- Readback semantics: the readback word stream is the chain's prior contents, tail cell first.
  - After a complete load, the chain holds the new words.
  - The bit fed first ends up in the tail cell.

## Timing

- Reset values (asynchronous, applied immediately on `rst`): state IDLE.
  - `busy`, `done`, `in_ready`, `out_valid`, `chain_d`, `chain_shift` = 0.
  - `out_data` = 0.
- Reset during SHIFT: `chain_shift` drops asynchronously. The chain keeps a partial shift. No `done` is issued. A new `start` is required.
- Per-word minimum time is 1 (FETCH) + `nbits` (SHIFT) + 1 (EMIT) cycles. A full load with no stalls takes `CHAIN_LEN` + 2·`NWORDS` cycles from `start`-accept to the `done` pulse.
- Exactly `CHAIN_LEN` `chain_shift` cycles occur per load; never more, never fewer.
- Stalls:
  - Low `in_valid` holds FETCH.
  - Low `out_ready` holds EMIT.
  - In both cases `chain_shift`=0 and `out_data` stays stable.
- Registered outputs: `in_ready`, `out_valid`, `chain_shift`, `chain_d` and `done` are decoded from registered state only. No combinational path from any input to any output.

## Test plan

1. **Basic load.** `CHAIN_LEN`=64, `WORD_W`=8, behavioural chain model preloaded with 0xFF. Send `start`, then words 0x01..0x08 with no stalls.
   - 64 `chain_shift` cycles.
   - 8 readback words, all 0xFF.
   - `done` exactly 80 cycles after `start`-accept.
   - Chain model tail→head reads back 0x01..0x08.
2. **Round trip.** Load pattern A = 0xA5×8, then load B = 0x3C×8 → the readback during the B load equals 0xA5×8.
3. **Partial last word.** `CHAIN_LEN`=20, `WORD_W`=8, words 0x12, 0x34, 0xF7 → 3 words accepted, 20 shifts total.
   - Third readback word has `out_data[7:4]`=0.
   - Only the low nibble 0x7 is loaded from the third word.
4. **Backpressure.** Drop `in_valid` for 3 cycles before word 2 and hold `out_ready`=0 for 5 cycles on word 4 → `chain_shift`=0 throughout both stalls, `out_data` constant during the EMIT stall, final chain contents identical to test 1.
5. **Reset mid-shift.** Assert `rst` on the 3rd shift cycle of word 2 → all outputs 0 within the same cycle and state IDLE. A following `start` completes a full, correct load.
6. **Ignored start.** Pulse `start` again during word 3 → no restart, total shifts still 64, exactly one `done` pulse.
